// File: rtl/uart_seq_pkg.sv
// Shared definitions for the UART MMIO sequencer: FSM states, UART register
// offsets within the peripheral window, and the STATUS register bit positions.
package uart_seq_pkg;

    typedef enum logic [2:0] {
        ST_INIT_BAUD,
        ST_INIT_CTRL,
        ST_POLL,
        ST_RD_DATA,
        ST_WR_DATA
    } seq_state_e;

    // Byte offsets of the UART slave registers
    localparam logic [31:0] UART_REG_DATA     = 32'h0000_0000;
    localparam logic [31:0] UART_REG_STATUS   = 32'h0000_0004;
    localparam logic [31:0] UART_REG_CTRL     = 32'h0000_0008;
    localparam logic [31:0] UART_REG_BAUD_DIV = 32'h0000_000C;

    // STATUS register bit positions
    localparam int STAT_RX_VALID      = 0;
    localparam int STAT_TX_READY      = 1;
    localparam int STAT_TX_PENDING    = 3;
    localparam int STAT_RX_OVERRUN    = 4;
    localparam int STAT_TX_CAN_ACCEPT = 5;

    // CTRL value for normal operation: TX_EN | RX_EN, interrupts disabled
    localparam logic [31:0] CTRL_INIT = 32'h0000_0003;

endpackage

// File: rtl/sync_fifo.sv
// Single-clock FIFO with wrap-bit pointers. Pushes into a full FIFO and pops
// from an empty FIFO are ignored; simultaneous push and pop are allowed.
module sync_fifo #(
    parameter int W     = 8,
    parameter int DEPTH = 4
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         push,
    input  logic [W-1:0] push_data,
    input  logic         pop,
    output logic [W-1:0] head,
    output logic         full,
    output logic         empty
);

    localparam int AW = $clog2(DEPTH);

    logic [W-1:0] mem [DEPTH];
    logic [AW:0]  wr_ptr;
    logic [AW:0]  rd_ptr;
    logic         do_push;
    logic         do_pop;

    assign empty   = (wr_ptr == rd_ptr);
    assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign head    = mem[rd_ptr[AW-1:0]];

    // Advance read and write pointers; the extra wrap bit separates full from empty
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
        end
    end

    // Storage array, written only on an accepted push
    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr[AW-1:0]] <= push_data;
    end

endmodule

// File: rtl/uart_mmio_sequencer.sv
// MMIO bus master that initialises the UART slave and then shuttles bytes
// between the UART DATA register and a TX/RX FIFO pair. Each DATA access is
// preceded by a fresh STATUS read, and requests are held until accepted.
module uart_mmio_sequencer
    import uart_seq_pkg::*;
#(
    parameter int          ADDR_W       = 32,
    parameter logic [31:0] BASE_ADDR    = 32'h0,
    parameter logic [15:0] BAUD_DIV_RST = 16'd0,
    parameter int          TX_DEPTH     = 4,
    parameter int          RX_DEPTH     = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              s_tx_valid,
    input  logic [7:0]        s_tx_data,
    output logic              s_tx_ready,
    output logic              m_rx_valid,
    output logic [7:0]        m_rx_data,
    input  logic              m_rx_ready,
    input  logic              cfg_baud_wr,
    input  logic [15:0]       cfg_baud_div,
    output logic              overrun_o,
    input  logic              overrun_clr,
    output logic              busy_o,
    output logic              mmio_valid,
    output logic              mmio_we,
    output logic [ADDR_W-1:0] mmio_addr,
    output logic [31:0]       mmio_wdata,
    output logic [3:0]        mmio_wstrb,
    input  logic [31:0]       mmio_rdata,
    input  logic              mmio_ready
);

    seq_state_e  state;
    seq_state_e  state_next;
    logic        active;
    logic [15:0] baud_reg;
    logic        baud_pend;
    logic        last_was_rx;
    logic        overrun;
    logic        fire;
    logic        req_we;
    logic [31:0] req_off;
    logic [31:0] req_wdata;
    logic        rx_want;
    logic        tx_want;

    logic        tx_full;
    logic        tx_empty;
    logic [7:0]  tx_head;
    logic        rx_full;
    logic        rx_empty;
    logic [7:0]  rx_head;
    logic        unused_rdata;

    assign unused_rdata = ^mmio_rdata[31:8];

    assign fire    = mmio_valid && mmio_ready;
    assign rx_want = mmio_rdata[STAT_RX_VALID] && !rx_full;
    assign tx_want = mmio_rdata[STAT_TX_CAN_ACCEPT] && !tx_empty;

    sync_fifo #(.W(8), .DEPTH(TX_DEPTH)) u_tx_fifo (
        .clk       (clk),
        .rst_n     (rst_n),
        .push      (s_tx_valid && s_tx_ready),
        .push_data (s_tx_data),
        .pop       ((state == ST_WR_DATA) && fire),
        .head      (tx_head),
        .full      (tx_full),
        .empty     (tx_empty)
    );

    sync_fifo #(.W(8), .DEPTH(RX_DEPTH)) u_rx_fifo (
        .clk       (clk),
        .rst_n     (rst_n),
        .push      ((state == ST_RD_DATA) && fire),
        .push_data (mmio_rdata[7:0]),
        .pop       (m_rx_ready && m_rx_valid),
        .head      (rx_head),
        .full      (rx_full),
        .empty     (rx_empty)
    );

    // Outputs are forced low while reset is asserted and in the first cycle after release
    assign s_tx_ready = active && !tx_full;
    assign m_rx_valid = !rx_empty;
    assign m_rx_data  = rx_empty ? 8'h00 : rx_head;
    assign overrun_o  = overrun;
    assign busy_o     = active && ((state != ST_POLL) || !tx_empty || !rx_empty);
    assign mmio_valid = active;
    assign mmio_we    = active && req_we;
    assign mmio_addr  = active ? (BASE_ADDR[ADDR_W-1:0] + req_off[ADDR_W-1:0]) : '0;
    assign mmio_wdata = active ? req_wdata : 32'h0;
    assign mmio_wstrb = active ? 4'hF : 4'h0;

    // Marks the sequencer live once a clock edge has passed outside reset
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) active <= 1'b0;
        else        active <= 1'b1;
    end

    // FSM state register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= ST_INIT_BAUD;
        else        state <= state_next;
    end

    // Request decode per state and next-state choice; the state only moves on fire
    always_comb begin
        state_next = state;
        req_we     = 1'b0;
        req_off    = UART_REG_STATUS;
        req_wdata  = 32'h0;
        case (state)
            ST_INIT_BAUD: begin
                req_we    = 1'b1;
                req_off   = UART_REG_BAUD_DIV;
                req_wdata = {16'h0, baud_reg};
                if (fire) state_next = ST_INIT_CTRL;
            end
            ST_INIT_CTRL: begin
                req_we    = 1'b1;
                req_off   = UART_REG_CTRL;
                req_wdata = CTRL_INIT;
                if (fire) state_next = ST_POLL;
            end
            ST_POLL: begin
                if (fire) begin
                    if (baud_pend)             state_next = ST_INIT_BAUD;
                    else if (rx_want && tx_want) state_next = last_was_rx ? ST_WR_DATA : ST_RD_DATA;
                    else if (rx_want)          state_next = ST_RD_DATA;
                    else if (tx_want)          state_next = ST_WR_DATA;
                    else                       state_next = ST_POLL;
                end
            end
            ST_RD_DATA: begin
                req_off = UART_REG_DATA;
                if (fire) state_next = ST_POLL;
            end
            ST_WR_DATA: begin
                req_we    = 1'b1;
                req_off   = UART_REG_DATA;
                req_wdata = {24'h0, tx_head};
                if (fire) state_next = ST_POLL;
            end
            default: state_next = ST_INIT_BAUD;
        endcase
    end

    // Baud reprogram request; a pulse coinciding with the BAUD_DIV write keeps it pending
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            baud_reg  <= BAUD_DIV_RST;
            baud_pend <= 1'b0;
        end else if (cfg_baud_wr) begin
            baud_reg  <= cfg_baud_div;
            baud_pend <= 1'b1;
        end else if ((state == ST_INIT_BAUD) && fire) begin
            baud_pend <= 1'b0;
        end
    end

    // Remembers the direction of the last DATA access for round-robin arbitration
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)                                last_was_rx <= 1'b0;
        else if ((state == ST_RD_DATA) && fire)    last_was_rx <= 1'b1;
        else if ((state == ST_WR_DATA) && fire)    last_was_rx <= 1'b0;
    end

    // Sticky overrun flag; a new overrun report wins over a clear in the same cycle
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            overrun <= 1'b0;
        else if ((state == ST_POLL) && fire && mmio_rdata[STAT_RX_OVERRUN])
            overrun <= 1'b1;
        else if (overrun_clr)
            overrun <= 1'b0;
    end

endmodule

// File: tb/tb_uart_mmio_sequencer.sv
// Self-checking bench for uart_mmio_sequencer: a transaction-level model of
// the expected MMIO request stream and byte streams, checked every cycle,
// plus directed scenarios with hand-computed expectations on the fire log.
module tb_uart_mmio_sequencer;

    localparam int          TX_DEPTH  = 4;
    localparam int          RX_DEPTH  = 4;
    localparam logic [15:0] BAUD_RST  = 16'h0000;
    localparam logic [31:0] A_DATA    = 32'h0;
    localparam logic [31:0] A_STATUS  = 32'h4;
    localparam logic [31:0] A_CTRL    = 32'h8;
    localparam logic [31:0] A_BAUD    = 32'hC;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        s_tx_valid = 1'b0;
    logic [7:0]  s_tx_data = 8'h0;
    logic        s_tx_ready;
    logic        m_rx_valid;
    logic [7:0]  m_rx_data;
    logic        m_rx_ready = 1'b0;
    logic        cfg_baud_wr = 1'b0;
    logic [15:0] cfg_baud_div = 16'h0;
    logic        overrun_o;
    logic        overrun_clr = 1'b0;
    logic        busy_o;
    logic        mmio_valid;
    logic        mmio_we;
    logic [31:0] mmio_addr;
    logic [31:0] mmio_wdata;
    logic [3:0]  mmio_wstrb;
    logic [31:0] mmio_rdata;
    logic        mmio_ready = 1'b1;

    logic [31:0] status_val = 32'h0;
    logic [7:0]  rx_byte = 8'h0;

    int vectors = 0;
    int miscompares = 0;

    uart_mmio_sequencer #(
        .ADDR_W(32), .BASE_ADDR(32'h0), .BAUD_DIV_RST(BAUD_RST),
        .TX_DEPTH(TX_DEPTH), .RX_DEPTH(RX_DEPTH)
    ) dut (
        .clk(clk), .rst_n(rst_n),
        .s_tx_valid(s_tx_valid), .s_tx_data(s_tx_data), .s_tx_ready(s_tx_ready),
        .m_rx_valid(m_rx_valid), .m_rx_data(m_rx_data), .m_rx_ready(m_rx_ready),
        .cfg_baud_wr(cfg_baud_wr), .cfg_baud_div(cfg_baud_div),
        .overrun_o(overrun_o), .overrun_clr(overrun_clr), .busy_o(busy_o),
        .mmio_valid(mmio_valid), .mmio_we(mmio_we), .mmio_addr(mmio_addr),
        .mmio_wdata(mmio_wdata), .mmio_wstrb(mmio_wstrb),
        .mmio_rdata(mmio_rdata), .mmio_ready(mmio_ready)
    );

    always #5 clk = ~clk;

    // UART slave stand-in: STATUS and DATA contents are set by the stimulus
    always_comb begin
        mmio_rdata = 32'h0;
        if (mmio_addr == A_STATUS)    mmio_rdata = status_val;
        else if (mmio_addr == A_DATA) mmio_rdata = {24'h0, rx_byte};
    end

    typedef enum int {K_BAUD, K_CTRL, K_STATUS, K_RD, K_WR} kind_e;
    typedef struct {
        bit          we;
        logic [31:0] addr;
        logic [31:0] data;
    } txn_t;

    kind_e       exp_kind = K_BAUD;
    logic [7:0]  tx_q[$];
    logic [7:0]  rx_q[$];
    txn_t        log_q[$];
    logic [15:0] baud_val_m = BAUD_RST;
    bit          pend_m = 0;
    bit          last_rx_m = 0;
    bit          ovr_m = 0;
    bit          settled = 0;

    task automatic check_output(input string name, input logic [31:0] act, input logic [31:0] req);
        vectors++;
        if (act !== req) begin
            miscompares++;
            $display("[TB] FAIL %s: got %h, expected %h", name, act, req);
        end
    endtask

    task automatic apply_stimulus(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Becomes true at the first clock edge after reset release
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) settled <= 1'b0;
        else        settled <= 1'b1;
    end

    // Model: compare DUT outputs with expectations, then advance on the coming edge
    always @(negedge clk) begin
        logic        exp_we;
        logic [31:0] exp_addr;
        logic [31:0] exp_wdata;
        bit          fire, tx_ok, ovr_set, rx_w, tx_w;
        int          rx_n, tx_n;
        txn_t        t;
        if (!rst_n) begin
            tx_q.delete(); rx_q.delete(); log_q.delete();
            exp_kind = K_BAUD; baud_val_m = BAUD_RST;
            pend_m = 0; last_rx_m = 0; ovr_m = 0;
            check_output("rst_mmio_valid", mmio_valid, 0);
            check_output("rst_s_tx_ready", s_tx_ready, 0);
            check_output("rst_m_rx_valid", m_rx_valid, 0);
            check_output("rst_busy", busy_o, 0);
            check_output("rst_overrun", overrun_o, 0);
        end else if (settled) begin
            exp_we = 1'b0; exp_addr = A_STATUS; exp_wdata = 32'h0;
            case (exp_kind)
                K_BAUD:   begin exp_we = 1'b1; exp_addr = A_BAUD; exp_wdata = {16'h0, baud_val_m}; end
                K_CTRL:   begin exp_we = 1'b1; exp_addr = A_CTRL; exp_wdata = 32'h3; end
                K_STATUS: begin exp_we = 1'b0; exp_addr = A_STATUS; end
                K_RD:     begin exp_we = 1'b0; exp_addr = A_DATA; end
                K_WR:     begin
                    exp_we = 1'b1; exp_addr = A_DATA;
                    exp_wdata = (tx_q.size() > 0) ? {24'h0, tx_q[0]} : 32'h0;
                end
                default:  ;
            endcase
            check_output("mmio_valid", mmio_valid, 1);
            check_output("mmio_we", mmio_we, exp_we);
            check_output("mmio_addr", mmio_addr, exp_addr);
            if (exp_we) check_output("mmio_wdata", mmio_wdata, exp_wdata);
            check_output("mmio_wstrb", mmio_wstrb, 4'hF);
            check_output("s_tx_ready", s_tx_ready, tx_q.size() < TX_DEPTH);
            check_output("m_rx_valid", m_rx_valid, rx_q.size() > 0);
            if (rx_q.size() > 0) check_output("m_rx_data", m_rx_data, rx_q[0]);
            check_output("overrun_o", overrun_o, ovr_m);
            check_output("busy_o", busy_o,
                         (exp_kind != K_STATUS) || (tx_q.size() > 0) || (rx_q.size() > 0));

            fire    = mmio_ready;
            tx_n    = tx_q.size();
            rx_n    = rx_q.size();
            tx_ok   = tx_n < TX_DEPTH;
            ovr_set = 0;
            if (m_rx_ready && rx_n > 0) void'(rx_q.pop_front());
            if (fire) begin
                t.we = exp_we; t.addr = exp_addr;
                t.data = exp_we ? mmio_wdata : mmio_rdata;
                log_q.push_back(t);
                case (exp_kind)
                    K_BAUD: begin
                        exp_kind = K_CTRL;
                        if (!cfg_baud_wr) pend_m = 0;
                    end
                    K_CTRL: exp_kind = K_STATUS;
                    K_STATUS: begin
                        ovr_set = mmio_rdata[4];
                        rx_w = mmio_rdata[0] && (rx_n < RX_DEPTH);
                        tx_w = mmio_rdata[5] && (tx_n > 0);
                        if (pend_m)           exp_kind = K_BAUD;
                        else if (rx_w && tx_w) exp_kind = last_rx_m ? K_WR : K_RD;
                        else if (rx_w)        exp_kind = K_RD;
                        else if (tx_w)        exp_kind = K_WR;
                        else                  exp_kind = K_STATUS;
                    end
                    K_RD: begin
                        rx_q.push_back(mmio_rdata[7:0]);
                        last_rx_m = 1; exp_kind = K_STATUS;
                    end
                    K_WR: begin
                        void'(tx_q.pop_front());
                        last_rx_m = 0; exp_kind = K_STATUS;
                    end
                    default: ;
                endcase
            end
            if (s_tx_valid && tx_ok) tx_q.push_back(s_tx_data);
            if (ovr_set)          ovr_m = 1;
            else if (overrun_clr) ovr_m = 0;
            if (cfg_baud_wr) begin
                baud_val_m = cfg_baud_div;
                pend_m = 1;
            end
        end
    end

    // Index of the nth DATA access after position 'from' (mode 0 read, 1 write, 2 either)
    function automatic int find_data(input int from, input int mode, input int nth);
        int seen = 0;
        for (int i = from; i < log_q.size(); i++) begin
            if (log_q[i].addr == A_DATA && (mode == 2 || int'(log_q[i].we) == mode)) begin
                if (seen == nth) return i;
                seen++;
            end
        end
        return -1;
    endfunction

    function automatic int count_data(input int from, input int mode);
        int n = 0;
        for (int i = from; i < log_q.size(); i++)
            if (log_q[i].addr == A_DATA && (mode == 2 || int'(log_q[i].we) == mode)) n++;
        return n;
    endfunction

    task automatic push_byte(input logic [7:0] b);
        bit ok = 0;
        s_tx_valid = 1'b1;
        s_tx_data  = b;
        for (int i = 0; i < 60; i++) begin
            @(negedge clk);
            if (s_tx_ready) begin ok = 1; break; end
        end
        @(posedge clk); #1;
        s_tx_valid = 1'b0;
        if (!ok) begin
            vectors++; miscompares++;
            $display("[TB] FAIL push_byte: byte %h not accepted within 60 cycles", b);
        end
    endtask

    task automatic wait_request(input logic [31:0] addr, input logic we);
        bit ok = 0;
        for (int i = 0; i < 60; i++) begin
            @(posedge clk); #1;
            if (mmio_valid && mmio_addr == addr && mmio_we == we) begin ok = 1; break; end
        end
        if (!ok) begin
            vectors++; miscompares++;
            $display("[TB] FAIL wait_request: no request addr %h we %0b within 60 cycles", addr, we);
        end
    endtask

    task automatic check_txn(input string name, input int idx, input bit we,
                             input logic [31:0] addr, input logic [31:0] data, input bit chk_data);
        if (idx < 0 || idx >= log_q.size()) begin
            vectors++; miscompares++;
            $display("[TB] FAIL %s: log entry %0d missing (log has %0d)", name, idx, log_q.size());
        end else begin
            check_output({name, "_we"}, log_q[idx].we, we);
            check_output({name, "_addr"}, log_q[idx].addr, addr);
            if (chk_data) check_output({name, "_data"}, log_q[idx].data, data);
        end
    endtask

    initial begin
        #100000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        int mark, idx;

        // 1: reset, then BAUD_DIV, CTRL, STATUS polls
        apply_stimulus(3);
        check_output("t1_rst_valid", mmio_valid, 0);
        rst_n = 1'b1;
        apply_stimulus(8);
        check_txn("t1_baud", 0, 1, A_BAUD, {16'h0, BAUD_RST}, 1);
        check_txn("t1_ctrl", 1, 1, A_CTRL, 32'h3, 1);
        check_txn("t1_poll", 2, 0, A_STATUS, 32'h0, 0);
        check_output("t1_busy_idle", busy_o, 0);

        // 2: two TX bytes, each DATA write preceded by a poll
        mark = log_q.size();
        status_val = 32'h20;
        push_byte(8'h55);
        push_byte(8'hAA);
        apply_stimulus(10);
        check_output("t2_writes", count_data(mark, 1), 2);
        idx = find_data(mark, 1, 0);
        check_txn("t2_wr0", idx, 1, A_DATA, 32'h55, 1);
        check_txn("t2_wr0_poll", idx - 1, 0, A_STATUS, 32'h0, 0);
        idx = find_data(mark, 1, 1);
        check_txn("t2_wr1", idx, 1, A_DATA, 32'hAA, 1);
        check_txn("t2_wr1_poll", idx - 1, 0, A_STATUS, 32'h0, 0);
        status_val = 32'h0;

        // 3: RX and TX both wanted -> alternate starting with a read
        push_byte(8'h11);
        apply_stimulus(2);
        mark = log_q.size();
        rx_byte = 8'h3C;
        status_val = 32'h21;
        apply_stimulus(20);
        check_txn("t3_first", find_data(mark, 2, 0), 0, A_DATA, 32'h3C, 1);
        check_txn("t3_second", find_data(mark, 2, 1), 1, A_DATA, 32'h11, 1);
        check_output("t3_reads_until_full", count_data(mark, 0), RX_DEPTH);
        check_output("t3_rx_valid", m_rx_valid, 1);
        check_output("t3_rx_data", m_rx_data, 32'h3C);

        // 4: RX FIFO full -> polls only; overrun sticky and clear
        mark = log_q.size();
        status_val = 32'h01;
        apply_stimulus(10);
        check_output("t4_no_reads", count_data(mark, 2), 0);
        status_val = 32'h10;
        apply_stimulus(3);
        check_output("t4_ovr_set", overrun_o, 1);
        overrun_clr = 1'b1;
        apply_stimulus(1);
        overrun_clr = 1'b0;
        check_output("t4_ovr_set_beats_clr", overrun_o, 1);
        status_val = 32'h0;
        apply_stimulus(2);
        check_output("t4_ovr_sticky", overrun_o, 1);
        overrun_clr = 1'b1;
        apply_stimulus(1);
        overrun_clr = 1'b0;
        check_output("t4_ovr_clr", overrun_o, 0);
        m_rx_ready = 1'b1;
        apply_stimulus(6);
        m_rx_ready = 1'b0;
        check_output("t4_drained", m_rx_valid, 0);

        // 5: stalled DATA write keeps address/data stable, single pop
        push_byte(8'h77);
        mark = log_q.size();
        status_val = 32'h20;
        wait_request(A_DATA, 1'b1);
        mmio_ready = 1'b0;
        for (int i = 0; i < 5; i++) begin
            apply_stimulus(1);
            check_output("t5_hold_addr", mmio_addr, A_DATA);
            check_output("t5_hold_wdata", mmio_wdata, 32'h77);
            check_output("t5_hold_ready", s_tx_ready, 1);
        end
        mmio_ready = 1'b1;
        apply_stimulus(6);
        check_output("t5_one_write", count_data(mark, 1), 1);
        check_txn("t5_wr", find_data(mark, 1, 0), 1, A_DATA, 32'h77, 1);
        status_val = 32'h0;

        // 6: baud change during a write, then reset during a read
        push_byte(8'h42);
        mark = log_q.size();
        status_val = 32'h20;
        wait_request(A_DATA, 1'b1);
        mmio_ready = 1'b0;
        cfg_baud_wr = 1'b1;
        cfg_baud_div = 16'h001B;
        apply_stimulus(1);
        cfg_baud_wr = 1'b0;
        apply_stimulus(2);
        mmio_ready = 1'b1;
        apply_stimulus(8);
        idx = find_data(mark, 1, 0);
        check_txn("t6_wr", idx, 1, A_DATA, 32'h42, 1);
        check_txn("t6_poll", idx + 1, 0, A_STATUS, 32'h0, 0);
        check_txn("t6_baud", idx + 2, 1, A_BAUD, 32'h1B, 1);
        check_txn("t6_ctrl", idx + 3, 1, A_CTRL, 32'h3, 1);
        status_val = 32'h0;
        push_byte(8'h12);
        rx_byte = 8'h99;
        status_val = 32'h01;
        wait_request(A_DATA, 1'b0);
        mmio_ready = 1'b0;
        #2;
        rst_n = 1'b0;
        #1;
        check_output("t6_async_valid", mmio_valid, 0);
        check_output("t6_async_txready", s_tx_ready, 0);
        apply_stimulus(2);
        rst_n = 1'b1;
        mmio_ready = 1'b1;
        status_val = 32'h20;
        apply_stimulus(10);
        check_txn("t6_rst_baud", 0, 1, A_BAUD, {16'h0, BAUD_RST}, 1);
        check_txn("t6_rst_ctrl", 1, 1, A_CTRL, 32'h3, 1);
        check_output("t6_tx_flushed", count_data(0, 2), 0);
        check_output("t6_rx_empty", m_rx_valid, 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
